lcd_bus_writer: RTL and testbench
=================================

Name: lcd_bus_writer

Overview:
- Downstream stage of the LCD controller buffer FSM; replaces the direct lcd_id write path.
- Accepts one 32-bit instruction per data_valid/write_ok handshake and serialises it onto the 16-bit 8080-style LCD write bus (cs/rs/wr/rd/data).
- Three transaction kinds:
  - register write: command + one data beat;
  - rectangle fill: command + graph_size repeated colour beats;
  - raw single beat: refresh or char pixel stream.

Parameters:
- WR_LOW_CYC, 1, pclk cycles lcd_wr held low per beat (1..15).
- WR_HIGH_CYC, 1, pclk cycles lcd_wr held high after rising edge per beat (1..15).
- FILL_CMD, 16'h2C00, command code that triggers repeated-colour fill.

Ports:
- pclk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- buffer_data  in  32  [31:16] command, [15:0] data/colour; raw beats use [15:0] only.
- buffer_addr  in  32  unused, reserved; ignored.
- data_valid  in  1  request; sampled only when write_ok=1.
- graph_size  in  32  fill beat count for FILL_CMD transactions.
- refresh  in  1  raw beat from refresh path.
- refresh_rs  in  1  rs value for refresh raw beat (0 = command, 1 = data).
- char_color  in  1  raw beat from char path.
- char_rs  in  1  rs value for char raw beat.
- write_ok  out  1  1 = idle, can accept.
- lcd_cs  out  1  chip select, active-low.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_wr  out  1  write strobe, active-low; panel latches on rising edge.
- lcd_rd  out  1  constant 1.
- lcd_data_o  out  16  bus data.
- lcd_data_oe  out  1  bus drive enable.
- debug_beats  out  32  beats remaining in current transaction.

Behaviour:
- Reset values, on any edge with rst_n=0, including mid-transaction: write_ok=1, lcd_cs=1, lcd_rs=1, lcd_wr=1, lcd_rd=1, lcd_data_o=0, lcd_data_oe=0, debug_beats=0, state IDLE. An in-flight transfer is aborted, not completed.
- All outputs are registered.
- Accept: in IDLE with data_valid=1, latch every input and go to SETUP. write_ok=0 from the next cycle.
- data_valid while write_ok=0 is ignored; the request is dropped, not queued.
- Classification at accept, priority order:
  1. refresh=1 -> 1 beat, rs=refresh_rs, value [15:0].
  2. char_color=1 -> 1 beat, rs=char_rs, value [15:0].
  3. [31:16]==FILL_CMD and graph_size!=0 -> command beat ([31:16], rs=0), then graph_size data beats of [15:0], rs=1.
  4. Otherwise -> command beat then one data beat. This includes FILL_CMD with graph_size=0.
- States:
  - IDLE (cs=1, oe=0, write_ok=1).
  - SETUP: 1 cycle; cs=0, oe=1, rs and data valid, wr=1.
  - WR_L: WR_LOW_CYC cycles; wr=0.
  - WR_H: WR_HIGH_CYC cycles; wr=1. If beats remain, go to SETUP; else go to DONE.
  - DONE: 1 cycle; cs=1, oe=0. Then IDLE.
- lcd_data_o and lcd_rs are stable from SETUP through WR_H of each beat.
- Beat = 1+WR_LOW_CYC+WR_HIGH_CYC cycles. With n beats and accept at cycle T:
  - write_ok low during T+1 .. T+n*(1+L+H)+1;
  - write_ok high at T+n*(1+L+H)+2.
  - Defaults, single beat: write_ok high at T+5.
- Fill counter: 32-bit down-counter loaded with graph_size. No wrap; 0xFFFF_FFFF is legal (long fill). debug_beats reports remaining beats, command beat included.
- Back-to-back: a new accept is possible in the first IDLE cycle after DONE.
- The upstream controller waits ≥2 cycles after issuing before checking write_ok. This block guarantees write_ok=0 by T+1, so no stale write_ok is observed.

Decomposition:
- Shared package lcd_pkg:
  - state enum (IDLE, SETUP, WR_L, WR_H, DONE);
  - transaction kind enum (RAW, REG, FILL);
  - constants FILL_CMD default and LCD_INPUT/TOUCH_INPUT addresses.
- Natural sub-module: lcd_wr_strobe. It generates one SETUP/WR_L/WR_H beat from a start pulse, with done output. The parent owns classification and beat counting.

Test Plan:
- Reg write: buffer_data=32'h2A00_0028, flags 0 -> beats (rs0,16'h2A00), (rs1,16'h0028). wr low at T+2 and T+5. write_ok high at T+8.
- Fill: buffer_data=32'h2C00_FF45, graph_size=3 -> 4 beats (2C00 cmd, FF45 ×3). cs low continuously T+1..T+12, high at T+13. write_ok high at T+14.
- Raw: refresh=1, refresh_rs=1, data=32'h0000_ABCD -> single beat rs=1, data ABCD. write_ok high at T+5. Repeat with char_color=1, char_rs=0 -> rs=0.
- Priority and edge cases:
  - refresh=1 and char_color=1, refresh_rs=0, char_rs=1 -> rs=0 (refresh wins).
  - FILL_CMD with graph_size=0 -> exactly 2 beats.
- Busy drop: second data_valid (32'h3600_0000) pulsed at T+2 during a transaction -> no extra beats; bus idle after DONE.
- Reset mid-fill: graph_size=1000, rst_n=0 at beat 10 -> next edge cs=1, wr=1, oe=0, write_ok=1, debug_beats=0. A fresh request after release completes normally.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write path: FSM states, transaction
// kinds and the classification rule applied when a request is accepted.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WR_L  = 3'd2,
    WR_H  = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RAW  = 2'd0,
    REG  = 2'd1,
    FILL = 2'd2
  } kind_t;

  localparam logic [15:0] FILL_CMD_DEF = 16'h2C00;
  localparam logic [31:0] LCD_INPUT    = 32'h0000_0000;
  localparam logic [31:0] TOUCH_INPUT  = 32'h0000_0004;

  // Raw paths win over any command decode; a zero-length fill degrades to a
  // plain register write so the command still reaches the panel.
  function automatic kind_t classify(input logic        refresh,
                                     input logic        char_color,
                                     input logic [15:0] cmd,
                                     input logic [15:0] fill_cmd,
                                     input logic [31:0] graph_size);
    if (refresh || char_color) return RAW;
    if ((cmd == fill_cmd) && (graph_size != 32'd0)) return FILL;
    return REG;
  endfunction

endpackage

// File: rtl/lcd_bus_writer_if.sv
// Request handshake from the buffer FSM plus the 8080-style LCD write bus.
// Handshake: a request is taken on a clock edge where write_ok=1 and
// data_valid=1; data_valid while write_ok=0 is dropped, never queued.
interface lcd_bus_writer_if;
  import lcd_pkg::*;

  logic [31:0] buffer_data;
  logic [31:0] buffer_addr;
  logic        data_valid;
  logic [31:0] graph_size;
  logic        refresh;
  logic        refresh_rs;
  logic        char_color;
  logic        char_rs;
  logic        write_ok;
  logic        lcd_cs;
  logic        lcd_rs;
  logic        lcd_wr;
  logic        lcd_rd;
  logic [15:0] lcd_data_o;
  logic        lcd_data_oe;
  logic [31:0] debug_beats;
  state_t      debug_state;

  modport master (
    output buffer_data, buffer_addr, data_valid, graph_size,
           refresh, refresh_rs, char_color, char_rs,
    input  write_ok, lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data_o,
           lcd_data_oe, debug_beats, debug_state
  );

  modport slave (
    input  buffer_data, buffer_addr, data_valid, graph_size,
           refresh, refresh_rs, char_color, char_rs,
    output write_ok, lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data_o,
           lcd_data_oe, debug_beats, debug_state
  );
endinterface

// File: rtl/lcd_wr_strobe.sv
// Sequences one SETUP / WR_L / WR_H beat per start pulse; done marks the last
// WR_H cycle so the parent can chain the next beat without a gap.
module lcd_wr_strobe
  import lcd_pkg::*;
#(
  parameter int unsigned WR_LOW_CYC  = 1,
  parameter int unsigned WR_HIGH_CYC = 1
) (
  input  logic   pclk,
  input  logic   rst_n,
  input  logic   start,
  output state_t phase_nxt,
  output logic   done
);

  localparam logic [3:0] LOW_LOAD  = 4'(WR_LOW_CYC - 1);
  localparam logic [3:0] HIGH_LOAD = 4'(WR_HIGH_CYC - 1);

  state_t     phase;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      phase <= IDLE;
      cnt   <= 4'd0;
    end else begin
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign done = (phase == WR_H) && (cnt == 4'd0);

  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = cnt;
    case (phase)
      SETUP: begin
        phase_nxt = WR_L;
        cnt_nxt   = LOW_LOAD;
      end
      WR_L: begin
        if (cnt == 4'd0) begin
          phase_nxt = WR_H;
          cnt_nxt   = HIGH_LOAD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      WR_H: begin
        if (cnt == 4'd0) phase_nxt = start ? SETUP : IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: begin
        if (start) phase_nxt = SETUP;
      end
    endcase
  end

endmodule

// File: rtl/lcd_bus_writer.sv
// Serialises one 32-bit buffer instruction into command/data beats on the
// 16-bit LCD write bus; outputs are registered from the next-state decode.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int unsigned WR_LOW_CYC  = 1,
  parameter int unsigned WR_HIGH_CYC = 1,
  parameter logic [15:0] FILL_CMD    = FILL_CMD_DEF
) (
  input logic             pclk,
  input logic             rst_n,
  lcd_bus_writer_if.slave bus
);

  state_t      state, state_nxt, phase_nxt;
  kind_t       kind_q, kind_c;
  logic [15:0] cmd_q, dat_q, cmd_c, dat_c;
  logic        raw_rs_q, raw_rs_c;
  logic        cmd_pend, cmd_pend_nxt;
  logic [31:0] data_cnt, data_cnt_nxt;
  logic        accept, start, done, last, beat;
  logic        write_ok_nxt, cs_nxt, rs_nxt, wr_nxt, oe_nxt;
  logic [15:0] data_nxt;
  logic [31:0] dbg_nxt;
  logic        addr_unused;

  assign addr_unused = ^bus.buffer_addr;

  assign accept   = (state == IDLE) && bus.data_valid;
  assign last     = !cmd_pend && (data_cnt == 32'd1);
  assign start    = accept || (done && !last);
  assign kind_c   = accept ? classify(bus.refresh, bus.char_color, bus.buffer_data[31:16],
                                      FILL_CMD, bus.graph_size) : kind_q;
  assign cmd_c    = accept ? bus.buffer_data[31:16] : cmd_q;
  assign dat_c    = accept ? bus.buffer_data[15:0]  : dat_q;
  assign raw_rs_c = accept ? (bus.refresh ? bus.refresh_rs : bus.char_rs) : raw_rs_q;

  lcd_wr_strobe #(
    .WR_LOW_CYC (WR_LOW_CYC),
    .WR_HIGH_CYC(WR_HIGH_CYC)
  ) u_strobe (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .start    (start),
    .phase_nxt(phase_nxt),
    .done     (done)
  );

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state    <= IDLE;
      kind_q   <= RAW;
      cmd_q    <= 16'd0;
      dat_q    <= 16'd0;
      raw_rs_q <= 1'b0;
      cmd_pend <= 1'b0;
      data_cnt <= 32'd0;
    end else begin
      state    <= state_nxt;
      kind_q   <= kind_c;
      cmd_q    <= cmd_c;
      dat_q    <= dat_c;
      raw_rs_q <= raw_rs_c;
      cmd_pend <= cmd_pend_nxt;
      data_cnt <= data_cnt_nxt;
    end
  end

  // The command beat is tracked by a flag so a 0xFFFF_FFFF fill never wraps.
  always_comb begin
    cmd_pend_nxt = cmd_pend;
    data_cnt_nxt = data_cnt;
    if (accept) begin
      case (kind_c)
        RAW:     begin cmd_pend_nxt = 1'b0; data_cnt_nxt = 32'd1;          end
        FILL:    begin cmd_pend_nxt = 1'b1; data_cnt_nxt = bus.graph_size; end
        default: begin cmd_pend_nxt = 1'b1; data_cnt_nxt = 32'd1;          end
      endcase
    end else if (done) begin
      if (cmd_pend) cmd_pend_nxt = 1'b0;
      else          data_cnt_nxt = data_cnt - 32'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SETUP;
      SETUP, WR_L, WR_H: begin
        if (done && last) state_nxt = DONE;
        else              state_nxt = phase_nxt;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    beat         = (state_nxt == SETUP) || (state_nxt == WR_L) || (state_nxt == WR_H);
    write_ok_nxt = (state_nxt == IDLE);
    cs_nxt       = !beat;
    oe_nxt       = beat;
    wr_nxt       = (state_nxt != WR_L);
    rs_nxt       = bus.lcd_rs;
    data_nxt     = bus.lcd_data_o;
    if (beat) begin
      if (kind_c == RAW) begin
        rs_nxt   = raw_rs_c;
        data_nxt = dat_c;
      end else if (cmd_pend_nxt) begin
        rs_nxt   = 1'b0;
        data_nxt = cmd_c;
      end else begin
        rs_nxt   = 1'b1;
        data_nxt = dat_c;
      end
    end
    if (cmd_pend_nxt) dbg_nxt = (&data_cnt_nxt) ? 32'hFFFF_FFFF : data_cnt_nxt + 32'd1;
    else              dbg_nxt = data_cnt_nxt;
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      bus.write_ok    <= 1'b1;
      bus.lcd_cs      <= 1'b1;
      bus.lcd_rs      <= 1'b1;
      bus.lcd_wr      <= 1'b1;
      bus.lcd_rd      <= 1'b1;
      bus.lcd_data_o  <= 16'd0;
      bus.lcd_data_oe <= 1'b0;
      bus.debug_beats <= 32'd0;
    end else begin
      bus.write_ok    <= write_ok_nxt;
      bus.lcd_cs      <= cs_nxt;
      bus.lcd_rs      <= rs_nxt;
      bus.lcd_wr      <= wr_nxt;
      bus.lcd_rd      <= 1'b1;
      bus.lcd_data_o  <= data_nxt;
      bus.lcd_data_oe <= oe_nxt;
      bus.debug_beats <= dbg_nxt;
    end
  end

  assign bus.debug_state = state;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed bench for lcd_bus_writer: per-cycle strobe patterns after accept
// and an expected-beat queue checked on every rising edge of lcd_wr.
module tb_lcd_bus_writer;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 pclk = ~pclk;

  lcd_bus_writer_if bus();

  lcd_bus_writer dut (
    .pclk (pclk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [16:0] exp_q[$];
  logic [63:0] cs_t, wr_t, ok_t, oe_t;
  logic [31:0] dbg_t [0:63];
  int          beats_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.buffer_data = 32'd0;
    bus.buffer_addr = 32'd0;
    bus.data_valid  = 1'b0;
    bus.graph_size  = 32'd0;
    bus.refresh     = 1'b0;
    bus.refresh_rs  = 1'b0;
    bus.char_color  = 1'b0;
    bus.char_rs     = 1'b0;
  endtask

  // Returns #1 after the accept edge T.
  task automatic issue(input logic [31:0] data, input logic [31:0] gs,
                       input logic rf, input logic rf_rs, input logic ch, input logic ch_rs);
    @(posedge pclk); #1;
    bus.buffer_data = data;
    bus.buffer_addr = $urandom;
    bus.graph_size  = gs;
    bus.refresh     = rf;
    bus.refresh_rs  = rf_rs;
    bus.char_color  = ch;
    bus.char_rs     = ch_rs;
    bus.data_valid  = 1'b1;
    @(posedge pclk); #1;
    drive_idle();
  endtask

  // Sample k corresponds to cycle T+k.
  task automatic capture(input string tag, input int ncyc);
    logic        prev_wr;
    int          n_exp;
    logic [16:0] e;
    prev_wr    = 1'b1;
    n_exp      = exp_q.size();
    beats_seen = 0;
    cs_t = '1; wr_t = '1; ok_t = '1; oe_t = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge pclk);
      cs_t[k]  = bus.lcd_cs;
      wr_t[k]  = bus.lcd_wr;
      ok_t[k]  = bus.write_ok;
      oe_t[k]  = bus.lcd_data_oe;
      dbg_t[k] = bus.debug_beats;
      if (!prev_wr && bus.lcd_wr) begin
        beats_seen++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check({tag, "_beat"}, {15'd0, bus.lcd_rs, bus.lcd_data_o}, {15'd0, e});
        end
      end
      prev_wr = bus.lcd_wr;
    end
    check({tag, "_nbeats"}, beats_seen, n_exp);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    repeat (3) @(posedge pclk);
    #1;
    check("rst_write_ok", bus.write_ok, 1);
    check("rst_cs", bus.lcd_cs, 1);
    check("rst_rs", bus.lcd_rs, 1);
    check("rst_wr", bus.lcd_wr, 1);
    check("rst_rd", bus.lcd_rd, 1);
    check("rst_data", bus.lcd_data_o, 0);
    check("rst_oe", bus.lcd_data_oe, 0);
    check("rst_dbg", bus.debug_beats, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge pclk);

    // Register write: command then one data beat.
    exp_q.push_back({1'b0, 16'h2A00});
    exp_q.push_back({1'b1, 16'h0028});
    issue(32'h2A00_0028, 32'd0, 0, 0, 0, 0);
    capture("reg", 10);
    check("reg_cs", cs_t[8:1], 8'b1100_0000);
    check("reg_wr", wr_t[8:1], 8'b1110_1101);
    check("reg_ok", ok_t[10:1], 10'b11_1000_0000);
    check("reg_oe", oe_t[8:1], 8'b0011_1111);
    check("reg_dbg1", dbg_t[1], 2);
    check("reg_rd", bus.lcd_rd, 1);

    // Fill: command plus three colour beats.
    exp_q.push_back({1'b0, 16'h2C00});
    repeat (3) exp_q.push_back({1'b1, 16'hFF45});
    issue(32'h2C00_FF45, 32'd3, 0, 0, 0, 0);
    capture("fill", 16);
    check("fill_cs", cs_t[14:1], 14'b11_0000_0000_0000);
    check("fill_wr", wr_t[14:1], 14'b11_1011_0110_1101);
    check("fill_ok", ok_t[14:1], 14'b10_0000_0000_0000);
    check("fill_dbg1", dbg_t[1], 4);
    check("fill_dbg4", dbg_t[4], 3);
    check("fill_dbg13", dbg_t[13], 0);

    // Raw refresh beat, data rs.
    exp_q.push_back({1'b1, 16'hABCD});
    issue(32'h0000_ABCD, 32'd0, 1, 1, 0, 0);
    capture("refresh", 6);
    check("refresh_cs", cs_t[5:1], 5'b11000);
    check("refresh_wr", wr_t[5:1], 5'b11101);
    check("refresh_ok", ok_t[5:1], 5'b10000);
    check("refresh_dbg1", dbg_t[1], 1);

    // Raw char beat, command rs.
    exp_q.push_back({1'b0, 16'hABCD});
    issue(32'h0000_ABCD, 32'd0, 0, 0, 1, 0);
    capture("char", 6);
    check("char_ok", ok_t[5:1], 5'b10000);

    // Both raw flags: refresh wins, upper half ignored.
    exp_q.push_back({1'b0, 16'h00EE});
    issue(32'h5555_00EE, 32'd7, 1, 0, 1, 1);
    capture("prio", 6);
    check("prio_ok", ok_t[5:1], 5'b10000);

    // Fill command with zero size behaves as a register write.
    exp_q.push_back({1'b0, 16'h2C00});
    exp_q.push_back({1'b1, 16'h1111});
    issue(32'h2C00_1111, 32'd0, 0, 0, 0, 0);
    capture("fill0", 10);
    check("fill0_ok", ok_t[8:1], 8'b1000_0000);

    // Request pulsed while busy is dropped.
    exp_q.push_back({1'b0, 16'h2B00});
    exp_q.push_back({1'b1, 16'h0010});
    issue(32'h2B00_0010, 32'd0, 0, 0, 0, 0);
    fork
      capture("busy", 14);
      begin
        @(posedge pclk); #1;
        bus.buffer_data = 32'h3600_0000;
        bus.data_valid  = 1'b1;
        @(posedge pclk); #1;
        bus.data_valid  = 1'b0;
      end
    join
    check("busy_cs", cs_t[14:7], 8'b1111_1111);
    check("busy_ok", ok_t[14:7], 8'b1111_1110);

    // Reset in the middle of a long fill.
    issue(32'h2C00_1234, 32'd1000, 0, 0, 0, 0);
    repeat (27) @(posedge pclk);
    #1;
    check("midfill_dbg", bus.debug_beats, 992);
    check("midfill_cs", bus.lcd_cs, 0);
    check("midfill_data", {15'd0, bus.lcd_rs, bus.lcd_data_o}, {15'd0, 1'b1, 16'h1234});
    rst_n = 1'b0;
    @(posedge pclk); #1;
    check("abort_cs", bus.lcd_cs, 1);
    check("abort_wr", bus.lcd_wr, 1);
    check("abort_oe", bus.lcd_data_oe, 0);
    check("abort_ok", bus.write_ok, 1);
    check("abort_dbg", bus.debug_beats, 0);
    check("abort_data", bus.lcd_data_o, 0);
    rst_n = 1'b1;
    @(posedge pclk);

    exp_q.push_back({1'b0, 16'h2A00});
    exp_q.push_back({1'b1, 16'h0028});
    issue(32'h2A00_0028, 32'd0, 0, 0, 0, 0);
    capture("post_rst", 10);
    check("post_rst_wr", wr_t[8:1], 8'b1110_1101);
    check("post_rst_ok", ok_t[8:1], 8'b1000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
